ad_cache_framer: RTL

- Consumer on the read side of the ADC ping-pong cache.
- On each buffer-switch pulse it drains one full cache half through the cache's rd/rdata read port.
- It emits the half as a framed word stream on a valid/ready interface: sync word, frame counter, NSAMP samples, checksum.
- It sits in the read clock domain between the cache and the packet/link logic.

---
 rtl/ad_cache_framer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ad_cache_framer.sv
// Read-side consumer of the ADC ping-pong cache: drains one cache half per switch
// pulse and emits it as a framed stream (sync, frame count, samples, checksum).
module ad_cache_framer #(
    parameter int                DATA_W     = 16,
    parameter int                NSAMP      = 1024,
    parameter int                RD_LAT     = 2,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] SYNC_WORD  = DATA_W'(16'hEB90)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch,
    output logic              rd,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              o_ready,
    output logic              busy,
    output logic [15:0]       frm_cnt,
    output logic [7:0]        ovf_cnt
);
    localparam int CW  = $clog2(NSAMP + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, SYNC, CNT, DATA, CSUM} state_t;

    state_t             state, state_nxt;
    logic [RD_LAT-1:0]  vld_pipe;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [FCW-1:0]     fifo_count, inflight;
    logic [CW-1:0]      issued, popped;
    logic [DATA_W-1:0]  sum;
    logic               push, pop, csum_done;

    assign push      = vld_pipe[RD_LAT-1];
    assign pop       = (state == DATA) && o_valid && o_ready;
    assign csum_done = (state == CSUM) && o_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + FCW'(vld_pipe[i]);
    end

    // Credit counts reads still in the cache pipeline so the FIFO cannot overflow.
    always_comb begin
        rd = 1'b0;
        if ((state == SYNC || state == CNT || state == DATA) && !switch &&
            issued < CW'(NSAMP) &&
            ({1'b0, fifo_count} + {1'b0, inflight}) < (FCW+1)'(FIFO_DEPTH))
            rd = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        o_valid   = 1'b0;
        o_last    = 1'b0;
        o_data    = '0;
        case (state)
            IDLE: if (switch) state_nxt = SYNC;
            SYNC: begin
                o_valid = 1'b1;
                o_data  = SYNC_WORD;
                if (o_ready) state_nxt = CNT;
            end
            CNT: begin
                o_valid = 1'b1;
                o_data  = DATA_W'(frm_cnt);
                if (o_ready) state_nxt = DATA;
            end
            DATA: begin
                o_valid = (fifo_count != '0);
                o_data  = mem[rd_ptr];
                if (o_valid && o_ready && popped == CW'(NSAMP - 1)) state_nxt = CSUM;
            end
            CSUM: begin
                o_valid = 1'b1;
                o_last  = 1'b1;
                o_data  = sum;
                if (o_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vld_pipe   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            issued     <= '0;
            popped     <= '0;
            sum        <= '0;
            frm_cnt    <= '0;
            ovf_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            vld_pipe[0] <= rd;
            for (int i = 1; i < RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;

            if (state == IDLE) issued <= '0;
            else if (rd)       issued <= issued + 1'b1;

            if (state == IDLE) popped <= '0;
            else if (pop)      popped <= popped + 1'b1;

            if (pop)            sum <= sum + o_data;
            else if (csum_done) sum <= '0;

            if (csum_done) frm_cnt <= frm_cnt + 16'd1;

            // A switch seen outside IDLE is dropped, only counted.
            if (switch && state != IDLE && ovf_cnt != 8'hFF)
                ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rdata;
    end
endmodule
